// File: rtl/dsp_mac_pkg.sv
// Shared types and widths for the dual-multiplier DSP MAC dot-product sequencer.
package dsp_mac_pkg;

  localparam int unsigned OP_W  = 8;
  localparam int unsigned RES_W = 27;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [OP_W-1:0] ax;
    logic [OP_W-1:0] ay;
    logic [OP_W-1:0] bx;
    logic [OP_W-1:0] by;
  } beat_t;

endpackage

// File: rtl/dsp_mac_dot_sequencer_if.sv
// Command, operand, result and DSP-side signals of the dot-product sequencer.
interface dsp_mac_dot_sequencer_if
  import dsp_mac_pkg::*;
#(
  parameter int unsigned LEN_W = 10
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             op_valid;
  logic             op_ready;
  logic [OP_W-1:0]  op_ax, op_ay, op_bx, op_by;
  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] res_data;
  logic [OP_W-1:0]  dsp_ax, dsp_ay, dsp_bx, dsp_by;
  logic             dsp_accumulate;
  logic [2:0]       dsp_ena;
  logic             dsp_clr;
  logic [RES_W-1:0] dsp_resulta;

  modport slave (
    input  cmd_valid, cmd_len, op_valid, op_ax, op_ay, op_bx, op_by, res_ready, dsp_resulta,
    output cmd_ready, op_ready, res_valid, res_data,
           dsp_ax, dsp_ay, dsp_bx, dsp_by, dsp_accumulate, dsp_ena, dsp_clr
  );

  modport master (
    output cmd_valid, cmd_len, op_valid, op_ax, op_ay, op_bx, op_by, res_ready, dsp_resulta,
    input  cmd_ready, op_ready, res_valid, res_data,
           dsp_ax, dsp_ay, dsp_bx, dsp_by, dsp_accumulate, dsp_ena, dsp_clr
  );

endinterface

// File: rtl/dsp_mac_res_fifo.sv
// First-word-fall-through result FIFO; head reads as zero while empty.
module dsp_mac_res_fifo
  import dsp_mac_pkg::*;
#(
  parameter int unsigned DEPTH = 4
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [RES_W-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [RES_W-1:0] data
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [RES_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, do_pop;

  assign valid  = (count != '0);
  assign full   = (count == FULL_CNT);
  assign data   = valid ? mem[rd_ptr] : '0;
  assign do_pop = pop && valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Outstanding-vector credits bound occupancy, so a push into a full FIFO is a bug.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/dsp_mac_dot_sequencer.sv
// Streams one dot product per command into the DSP MAC and collects the framed sums.
module dsp_mac_dot_sequencer
  import dsp_mac_pkg::*;
#(
  parameter int unsigned MAC_LAT   = 3,
  parameter int unsigned LEN_W     = 10,
  parameter int unsigned RES_DEPTH = 4
)(
  input  logic                          clk0,
  input  logic                          clr0_n,
  dsp_mac_dot_sequencer_if.slave        bus,
  output logic                          busy
);
  localparam int unsigned OUT_W = $clog2(RES_DEPTH) + 1;
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(RES_DEPTH);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  state_t             state, state_nx;
  logic [LEN_W-1:0]   cnt, cnt_nx;
  logic               first, first_nx, zero_vec, zero_vec_nx;
  logic [OUT_W-1:0]   outstanding;
  beat_t              beat_q, beat_nx, op_beat;
  logic               acc_q, acc_nx, last_q, last_nx;
  logic [MAC_LAT-1:0] tag_line;
  logic               cmd_fire, op_fire, res_fire, push;

  assign op_beat       = {bus.op_ax, bus.op_ay, bus.op_bx, bus.op_by};
  assign bus.cmd_ready = (state == IDLE) && (outstanding < OUT_MAX) && clr0_n;
  assign bus.op_ready  = (state == RUN) && !zero_vec;
  assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
  assign op_fire       = bus.op_valid && bus.op_ready;
  assign res_fire      = bus.res_valid && bus.res_ready;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    first_nx    = first;
    zero_vec_nx = zero_vec;
    beat_nx     = '0;
    acc_nx      = 1'b0;
    last_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_fire) begin
          cnt_nx      = (bus.cmd_len == '0) ? ONE : bus.cmd_len;
          first_nx    = 1'b1;
          zero_vec_nx = (bus.cmd_len == '0);
          state_nx    = RUN;
        end
      end
      RUN: begin
        // A zero-length vector still issues one synthetic beat so a zero sum gets tagged.
        if (zero_vec || op_fire) begin
          cnt_nx  = cnt - ONE;
          last_nx = (cnt == ONE);
          if (op_fire) begin
            beat_nx  = op_beat;
            acc_nx   = !first;
            first_nx = 1'b0;
          end
        end else begin
          acc_nx = !first;
        end
        if (last_nx) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk0 or negedge clr0_n) begin
    if (!clr0_n) begin
      state       <= IDLE;
      cnt         <= '0;
      first       <= 1'b0;
      zero_vec    <= 1'b0;
      beat_q      <= '0;
      acc_q       <= 1'b0;
      last_q      <= 1'b0;
      tag_line    <= '0;
      outstanding <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      first    <= first_nx;
      zero_vec <= zero_vec_nx;
      beat_q   <= beat_nx;
      acc_q    <= acc_nx;
      last_q   <= last_nx;
      // last_q is aligned with the beat on dsp_*, so the tag exits as its sum lands.
      tag_line[0] <= last_q;
      for (int unsigned i = 1; i < MAC_LAT; i++) tag_line[i] <= tag_line[i-1];
      case ({cmd_fire, res_fire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
    end
  end

  assign push = tag_line[MAC_LAT-1];

  dsp_mac_res_fifo #(.DEPTH(RES_DEPTH)) u_res_fifo (
    .clk       (clk0),
    .rst_n     (clr0_n),
    .push      (push),
    .push_data (bus.dsp_resulta),
    .pop       (bus.res_ready),
    .valid     (bus.res_valid),
    .data      (bus.res_data)
  );

  assign bus.dsp_ax         = beat_q.ax;
  assign bus.dsp_ay         = beat_q.ay;
  assign bus.dsp_bx         = beat_q.bx;
  assign bus.dsp_by         = beat_q.by;
  assign bus.dsp_accumulate = acc_q;
  assign bus.dsp_ena        = {3{clr0_n}};
  assign bus.dsp_clr        = !clr0_n;
  assign busy               = (state != IDLE) || (outstanding != '0);

endmodule

// File: doc/dsp_mac_dot_sequencer.md
# dsp_mac_dot_sequencer

Controller that sequences the 8-bit dual-multiplier DSP MAC (resulta = ax·ay + bx·by, accumulated) to compute one dot product per command. Accepts a vector length command, streams operand pairs into the DSP with correct accumulate framing, and tracks the DSP pipeline latency. Captures each finished sum into a result FIFO with credit-based flow control. Sits between the operand/command source and the DSP hard block.

## Interface
- MAC_LAT, 3: cycles from a beat on dsp_* outputs to its accumulated sum on dsp_resulta (1..8)
- LEN_W, 10: width of cmd_len
- RES_DEPTH, 4: result FIFO depth, equal to max outstanding vectors (power of 2, ≥2)

Ports:
- clk0  in  1  single clock
- clr0_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_len  in  LEN_W  beats in vector; 0 allowed
- op_valid  in  1  operand beat offered
- op_ready  out  1  beat accepted when both high
- op_ax, op_ay, op_bx, op_by  in  8 each  operand pair
- res_valid  out  1  result available
- res_ready  in  1  result popped when both high
- res_data  out  27  dot-product sum
- dsp_ax, dsp_ay, dsp_bx, dsp_by  out  8 each  DSP operands (registered)
- dsp_accumulate  out  1  DSP accumulate (registered)
- dsp_ena  out  3  DSP clock enables
- dsp_clr  out  1  DSP clr0/clr1, active-high
- dsp_resulta  in  27  DSP result
- busy  out  1  state≠IDLE or outstanding≠0

## Operation
- States: IDLE, RUN.
- IDLE: cmd_ready = (outstanding < RES_DEPTH). On cmd handshake, load beat counter = max(cmd_len,1), set first=1, set zero_vec = (cmd_len==0), outstanding++, go RUN.
- RUN: op_ready = !zero_vec. Each cycle drive one beat on dsp_*:
  - beat accepted: operands = op_*, dsp_accumulate = !first, first←0, counter--.
  - zero_vec: operands = 0, accumulate = 0, counter-- (one synthetic beat).
  - no beat (bubble): operands = 0, dsp_accumulate = !first; counter unchanged. Sum is unaffected.
  - Beat with counter==1 is last: tag=1 into MAC_LAT-deep shift register, next state IDLE. All other beats and bubbles tag=0.
- Tag exiting the delay line: push dsp_resulta into result FIFO in that same cycle.
- FIFO head drives res_valid/res_data. Pop on res handshake, outstanding--.
- Push and pop in the same cycle are legal; occupancy unchanged.
- Credit scheme guarantees the FIFO never overflows. Push while full is a verification error (assertion).
- cmd_ready is low in RUN. There is exactly one IDLE cycle between vectors.
- Simultaneous cmd accept and result pop in IDLE: outstanding unchanged.
- dsp_ena = 3'b111 whenever clr0_n is high. dsp_clr = !clr0_n.
- Reset mid-vector: all state, the delay line, the FIFO and outstanding are cleared. Partial sums are discarded and no result is emitted.
- Arithmetic: the DSP performs it; the controller passes operands unmodified. No overflow detection. The 27-bit sum wraps per the DSP.

## Timing
- Reset values: cmd_ready 0 while clr0_n low, 1 in the first cycle after release. op_ready 0. res_valid 0. res_data 0. dsp_* operands 0. dsp_accumulate 0. dsp_ena 0. dsp_clr 1. busy 0.
- A beat accepted at edge t appears on dsp_* during cycle t+1.
- Its sum is valid on dsp_resulta at t+1+MAC_LAT and is pushed at that edge.
- res_valid rises the next cycle. Command-to-result latency for an N-beat, bubble-free vector: N+MAC_LAT+2 cycles.
- Throughput: one beat per cycle while op_valid is high.

## Structure
- Shared package dsp_mac_pkg holds:
  - OP_W=8 and RES_W=27
  - state enum {IDLE, RUN}
  - the beat struct {ax, ay, bx, by}
- Sub-module dsp_mac_res_fifo: synchronous FIFO, RES_DEPTH×RES_W, first-word-fall-through, async active-low reset.
- The delay line and FSM stay in the top module.
- The DSP itself is not instantiated here. The parent connects it, which lets the bench use a behavioural model with the same MAC_LAT.

## Test plan
- cmd_len=4, ax=ay=bx=by=k for k=1..4, no bubbles -> res_data=60 at cycle cmd+4+3+2; dsp_accumulate pattern 0,1,1,1.
- Same vector with op_valid low for 2 cycles after beat 2 -> res_data=60; result delayed by 2 cycles.
- cmd_len=0 -> op_ready stays low, single result 0, busy low afterwards.
- res_ready=0; issue 5 single-beat commands (values 1..5) -> 4 accepted, cmd_ready low on 5th until one pop; results pop in order 2,8,18,32,50.
- Back-to-back vectors len=1 with ax=ay=255, bx=by=255 -> each result 130050; second sum not contaminated by first (accumulate=0 on first beat).
- Assert clr0_n low mid-vector (after 2 of 4 beats) -> all outputs at reset values; no res_valid; next command after release computes correctly.
